// File: rtl/hex_scan_scheduler.sv
// Round-robin scan of NUM_DIGITS 4-bit values through one shared 7-segment decoder,
// with a dark gap before every digit to stop ghosting between neighbouring slots.
//
// state   | meaning
// S_BLANK | all digits off, dec_q holds the upcoming digit so the decoder settles
// S_DRIVE | digit idx lit, seg_n follows dec_seg (or forced off by blank[idx])
module hex_scan_scheduler #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int AW          = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic [NUM_DIGITS-1:0] blank,
    output logic [3:0]            dec_q,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic                  frame_done
);
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
    localparam logic [CW-1:0]         B_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]         D_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0]         IDX_TOP = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]           NUM_W   = (AW + 1)'(NUM_DIGITS);
    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [AW-1:0]           idx, idx_nxt;
    logic [3:0]              q_nxt;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   dig_nxt;
    logic                    fd_nxt;
    logic [3:0]              digit_reg [NUM_DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= 4'h0;
        end else if (wr_en && ({1'b0, wr_addr} < NUM_W)) begin
            digit_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BLANK;
            cnt        <= '0;
            idx        <= '0;
            dec_q      <= 4'h0;
            seg_n      <= SEG_OFF;
            dig_en_n   <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            dec_q      <= q_nxt;
            seg_n      <= seg_nxt;
            dig_en_n   <= dig_nxt;
            frame_done <= fd_nxt;
        end
    end

    // Outputs are next-values: lit on every edge that enters or stays in DRIVE, dark otherwise.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        q_nxt     = dec_q;
        seg_nxt   = SEG_OFF;
        dig_nxt   = '1;
        fd_nxt    = 1'b0;
        case (state)
            S_BLANK: begin
                if (cnt == B_LAST) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = '0;
                    dig_nxt   = ~(ONE << idx);
                    seg_nxt   = blank[idx] ? SEG_OFF : dec_seg;
                end
            end
            S_DRIVE: begin
                if (cnt == D_LAST) begin
                    state_nxt = S_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_TOP) ? '0 : idx + AW'(1);
                    q_nxt     = digit_reg[idx_nxt];
                    fd_nxt    = (idx_nxt == '0);
                end else begin
                    dig_nxt   = ~(ONE << idx);
                    seg_nxt   = blank[idx] ? SEG_OFF : dec_seg;
                end
            end
            default: begin
                state_nxt = S_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Scoreboarded bench: a closed-form timing model predicts every cycle's outputs for a
// 4-digit and a 3-digit scheduler sharing stimulus; a monitor pops and compares.
module tb_hex_scan_scheduler;
    localparam int B = 2;
    localparam int D = 4;
    localparam int PER = B + D;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic [3:0] q;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] blank = 4'd0;

    logic [3:0] q4, q3;
    logic [6:0] dseg4, dseg3, seg4, seg3;
    logic [3:0] dig4;
    logic [2:0] dig3;
    logic       fd4, fd3;

    int checks = 0;
    int failures = 0;

    exp_t sb4[$];
    exp_t sb3[$];
    int   k = 0;
    logic [3:0] m_regs [2][4];
    logic [3:0] snap [2];

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    assign dseg4 = dec7(q4);
    assign dseg3 = dec7(q3);

    hex_scan_scheduler #(.NUM_DIGITS(4), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blank(blank), .dec_q(q4), .dec_seg(dseg4), .seg_n(seg4), .dig_en_n(dig4),
        .frame_done(fd4));

    hex_scan_scheduler #(.NUM_DIGITS(3), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blank(blank[2:0]), .dec_q(q3), .dec_seg(dseg3), .seg_n(seg3), .dig_en_n(dig3),
        .frame_done(fd3));

    always #5 clk = ~clk;

    // Model: after the k-th edge since reset release, slot = (k/PER)%n is lit when
    // k%PER >= B; its value is snapshotted at the edge k%PER == 0, before that edge's write.
    initial begin
        for (int u = 0; u < 2; u++) begin
            snap[u] = 4'h0;
            for (int i = 0; i < 4; i++) m_regs[u][i] = 4'h0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0;
                for (int u = 0; u < 2; u++) begin
                    snap[u] = 4'h0;
                    for (int i = 0; i < 4; i++) m_regs[u][i] = 4'h0;
                end
                sb4.delete();
                sb3.delete();
            end else begin
                k++;
                for (int u = 0; u < 2; u++) begin
                    int   n, slot;
                    bit   lit;
                    exp_t e;
                    n    = (u == 0) ? 4 : 3;
                    slot = (k / PER) % n;
                    lit  = (k % PER) >= B;
                    if (k % PER == 0) snap[u] = m_regs[u][slot];
                    e.dig = lit ? ~(4'b0001 << slot) : 4'hF;
                    e.seg = (lit && !blank[slot]) ? dec7(snap[u]) : 7'h7F;
                    e.q   = snap[u];
                    e.fd  = (k % (n * PER) == 0);
                    if (u == 0) sb4.push_back(e); else sb3.push_back(e);
                end
                for (int u = 0; u < 2; u++)
                    if (wr_en && int'(wr_addr) < ((u == 0) ? 4 : 3)) m_regs[u][wr_addr] = wr_data;
            end
        end
    end

    task automatic compare(input string name, input exp_t exp, input exp_t act);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d: got dig=%b seg=%b q=%h fd=%b, expected dig=%b seg=%b q=%h fd=%b",
                     name, k, act.dig, act.seg, act.q, act.fd, exp.dig, exp.seg, exp.q, exp.fd);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sb4.size() > 0) compare("scan_n4", sb4.pop_front(), {dig4, seg4, q4, fd4});
                if (sb3.size() > 0) compare("scan_n3", sb3.pop_front(), {1'b1, dig3, seg3, q3, fd3});
            end
        end
    end

    task automatic check_reset(input string name);
        compare({name, "_n4"}, {4'hF, 7'h7F, 4'h0, 1'b0}, {dig4, seg4, q4, fd4});
        compare({name, "_n3"}, {4'hF, 7'h7F, 4'h0, 1'b0}, {1'b1, dig3, seg3, q3, fd3});
    endtask

    task automatic wait_dig4(input logic [3:0] target);
        int i;
        for (i = 0; i < 200 && dig4 !== target; i++) @(negedge clk);
        checks++;
        if (dig4 !== target) begin
            failures++;
            $display("FAIL wait_dig4 timeout: got dig=%b, expected dig=%b", dig4, target);
        end
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] v);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #23;
        check_reset("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        write(2'd0, 4'd3); write(2'd1, 4'd5); write(2'd2, 4'd7); write(2'd3, 4'd8);
        repeat (60) @(negedge clk);

        blank = 4'b0100;
        repeat (30) @(negedge clk);
        blank = 4'b0000;

        wait_dig4(4'b1101);
        write(2'd1, 4'd6);
        repeat (40) @(negedge clk);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            wr_en   = ($urandom % 3) == 0;
            wr_addr = 2'($urandom % 4);
            wr_data = 4'($urandom % 16);
            if ($urandom % 40 == 0) blank = 4'($urandom % 16);
        end
        wr_en = 1'b0;
        blank = 4'b0000;

        wait_dig4(4'b1011);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid_drive");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd9;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        check_reset("reset_hold");
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time=%0t, expected finish before it", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule
